// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-level frame constants, default divisor width.
// Latency: none (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int   DIV_WIDTH_DEF = 16;
   localparam logic START_BIT     = 1'b0;
   localparam logic STOP_BIT      = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: down-counts the latched divisor and strobes bit_tick_o once per period.
// Latency: first tick div_i+1 enabled cycles after load_i, then every div_i+1 enabled cycles.
// Backpressure: none; en_i low freezes the count.
module uart_bit_timer #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 load_i,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 bit_tick_o
);

   logic [DIV_WIDTH-1:0] period_q, period_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   // Reload happens on the zero cycle itself, so the counter never underflows.
   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         period_d = div_i;
         cnt_d    = div_i;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            cnt_d = period_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Divisor and counter registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         period_q <= '0;
         cnt_q    <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bit_tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops the TX FIFO and serializes start, data LSB-first, optional parity, 1/2 stop bits.
// Latency: pop at T, byte captured at T+1, txd_o falls at T+2; frame_done_o the cycle after the last stop bit.
// Backpressure: stalls in IDLE while the FIFO is empty or tx_en_i is low; a frame in flight always completes.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  tx_en_i,
   input  logic [DIV_WIDTH-1:0]  baud_div_i,
   input  logic                  parity_en_i,
   input  logic                  parity_odd_i,
   input  logic                  stop2_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   output logic                  fifo_rden_o,
   output logic                  txd_o,
   output logic                  busy_o,
   output logic                  frame_done_o
);

   // DATA_WIDTH must be at least 2 so the bit counter has a nonzero width.
   localparam int             BCW      = $clog2(DATA_WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   uart_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                  par_q, par_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_odd_q, par_odd_d;
   logic                  stop2_q, stop2_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  rden_q, rden_d;
   logic                  done_q, done_d;
   logic                  bit_tick;
   logic                  timer_en;

   assign timer_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                     (state_q == ST_PARITY) || (state_q == ST_STOP);

   uart_bit_timer #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_bit_timer (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .load_i     (state_q == ST_LOAD),
      .en_i       (timer_en),
      .div_i      (baud_div_i),
      .bit_tick_o (bit_tick)
   );

   // Next-state, datapath and registered-output decode; outputs derive from the next state so they are flops.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      par_d      = par_q;
      stop_cnt_d = stop_cnt_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      stop2_d    = stop2_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_en_i && !fifo_empty_i) state_d = ST_POP;
         end
         ST_POP: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // Frame format is frozen here; later config writes wait for the next frame.
            shift_d    = fifo_rd_data_i;
            par_en_d   = parity_en_i;
            par_odd_d  = parity_odd_i;
            stop2_d    = stop2_i;
            par_d      = 1'b0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            state_d    = ST_START;
         end
         ST_START: begin
            if (bit_tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick) begin
               par_d   = par_q ^ shift_q[0];
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (bit_tick) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = (tx_en_i && !fifo_empty_i) ? ST_POP : ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_START:  txd_d = START_BIT;
         ST_DATA:   txd_d = shift_d[0];
         ST_PARITY: txd_d = par_d ^ par_odd_d;
         default:   txd_d = STOP_BIT;
      endcase
      busy_d = (state_d != ST_IDLE);
      rden_d = (state_d == ST_POP);
   end

   // State, datapath and output registers; reset drops the byte in flight and idles the line.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_q      <= 1'b0;
         stop_cnt_q <= 1'b0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
         txd_q      <= STOP_BIT;
         busy_q     <= 1'b0;
         rden_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         stop_cnt_q <= stop_cnt_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         stop2_q    <= stop2_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         rden_q     <= rden_d;
         done_q     <= done_d;
      end
   end

   assign txd_o        = txd_q;
   assign busy_o       = busy_q;
   assign fifo_rden_o  = rden_q;
   assign frame_done_o = done_q;

endmodule
